// File: rtl/iob_axi_master.sv
// iob_axi_master
// Bridges a native valid/ready request port onto a single-beat AXI4 master.
// Only one transaction is in flight at a time. Each request is a single
// 32-bit transfer: a nonzero wstrb selects a write, a zero wstrb selects a read.
//
// Ports
//   clk, rst            : system clock; synchronous active-high reset
//   valid/addr/wdata/wstrb : native request, held high until ready
//   rdata, ready        : registered read data; one-cycle completion pulse
//   m_axi_aw*/w*/b*     : AXI4 write address, write data and write response channels
//   m_axi_ar*/r*        : AXI4 read address and read data channels
//   err                 : response error flag, valid while ready=1
//                         (present only when IOB_AXI_MASTER_ERR_EN is defined)
//
// Optional feature macro: IOB_AXI_MASTER_ERR_EN
//
// state        | meaning
// IDLE         | waiting for a request; captures addr/wdata/wstrb
// WR_ADDR_DATA | AW and W offered in parallel, each dropped after its own handshake
// WR_RESP      | bready high, waiting for the write response
// RD_ADDR      | arvalid high, waiting for arready
// RD_DATA      | rready high, waiting for the read beat
module iob_axi_master #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                valid,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    output logic [DATA_W-1:0]   rdata,
    output logic                ready,
    output logic                m_axi_awid,
    output logic [ADDR_W-1:0]   m_axi_awaddr,
    output logic [7:0]          m_axi_awlen,
    output logic [2:0]          m_axi_awsize,
    output logic [1:0]          m_axi_awburst,
    output logic                m_axi_awlock,
    output logic [3:0]          m_axi_awcache,
    output logic [2:0]          m_axi_awprot,
    output logic [3:0]          m_axi_awqos,
    output logic                m_axi_awvalid,
    input  logic                m_axi_awready,
    output logic [DATA_W-1:0]   m_axi_wdata,
    output logic [DATA_W/8-1:0] m_axi_wstrb,
    output logic                m_axi_wlast,
    output logic                m_axi_wvalid,
    input  logic                m_axi_wready,
    input  logic                m_axi_bid,
    input  logic [1:0]          m_axi_bresp,
    input  logic                m_axi_bvalid,
    output logic                m_axi_bready,
    output logic                m_axi_arid,
    output logic [ADDR_W-1:0]   m_axi_araddr,
    output logic [7:0]          m_axi_arlen,
    output logic [2:0]          m_axi_arsize,
    output logic [1:0]          m_axi_arburst,
    output logic                m_axi_arlock,
    output logic [3:0]          m_axi_arcache,
    output logic [2:0]          m_axi_arprot,
    output logic [3:0]          m_axi_arqos,
    output logic                m_axi_arvalid,
    input  logic                m_axi_arready,
    input  logic                m_axi_rid,
    input  logic [DATA_W-1:0]   m_axi_rdata,
    input  logic [1:0]          m_axi_rresp,
    input  logic                m_axi_rlast,
    input  logic                m_axi_rvalid,
    output logic                m_axi_rready
`ifdef IOB_AXI_MASTER_ERR_EN
    ,
    output logic                err
`endif
);

    typedef enum logic [2:0] {
        IDLE,
        WR_ADDR_DATA,
        WR_RESP,
        RD_ADDR,
        RD_DATA
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [ADDR_W-1:0]     r_addr;
    logic [DATA_W-1:0]     r_wdata;
    logic [DATA_W/8-1:0]   r_wstrb;
    logic [DATA_W-1:0]     r_rdata;
    logic                  r_ready;
    logic                  r_aw_done;
    logic                  r_w_done;
    logic                  w_accept;
    logic                  w_aw_hs;
    logic                  w_w_hs;
    logic                  w_b_hs;
    logic                  w_r_hs;
    logic                  w_unused;

    assign w_aw_hs = m_axi_awvalid & m_axi_awready;
    assign w_w_hs  = m_axi_wvalid & m_axi_wready;
    assign w_b_hs  = m_axi_bvalid & m_axi_bready;
    assign w_r_hs  = m_axi_rvalid & m_axi_rready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next        = r_state;
        w_accept      = 1'b0;
        m_axi_awvalid = 1'b0;
        m_axi_wvalid  = 1'b0;
        m_axi_bready  = 1'b0;
        m_axi_arvalid = 1'b0;
        m_axi_rready  = 1'b0;
        case (r_state)
            IDLE: begin
                // The request still on the bus during the ready pulse is the
                // one just completed; it is only sampled again a cycle later.
                if (valid && !r_ready) begin
                    w_accept = 1'b1;
                    w_next   = (|wstrb) ? WR_ADDR_DATA : RD_ADDR;
                end
            end
            WR_ADDR_DATA: begin
                m_axi_awvalid = ~r_aw_done;
                m_axi_wvalid  = ~r_w_done;
                if ((r_aw_done || m_axi_awready) && (r_w_done || m_axi_wready)) begin
                    w_next = WR_RESP;
                end
            end
            WR_RESP: begin
                m_axi_bready = 1'b1;
                if (m_axi_bvalid) begin
                    w_next = IDLE;
                end
            end
            RD_ADDR: begin
                m_axi_arvalid = 1'b1;
                if (m_axi_arready) begin
                    w_next = RD_DATA;
                end
            end
            RD_DATA: begin
                m_axi_rready = 1'b1;
                if (m_axi_rvalid) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr    <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_rdata   <= '0;
            r_ready   <= 1'b0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end else begin
            r_ready <= 1'b0;
            if (w_accept) begin
                r_addr    <= {addr[ADDR_W-1:2], 2'b00};
                r_wdata   <= wdata;
                r_wstrb   <= wstrb;
                r_aw_done <= 1'b0;
                r_w_done  <= 1'b0;
            end
            if (w_aw_hs) begin
                r_aw_done <= 1'b1;
            end
            if (w_w_hs) begin
                r_w_done <= 1'b1;
            end
            if (w_b_hs) begin
                r_ready <= 1'b1;
            end
            if (w_r_hs) begin
                r_ready <= 1'b1;
                r_rdata <= m_axi_rdata;
            end
        end
    end

`ifdef IOB_AXI_MASTER_ERR_EN
    logic r_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_b_hs) begin
            r_err <= |m_axi_bresp;
        end else if (w_r_hs) begin
            r_err <= |m_axi_rresp;
        end
    end

    assign err      = r_err;
    assign w_unused = ^{m_axi_bid, m_axi_rid, m_axi_rlast, addr[1:0]};
`else
    assign w_unused = ^{m_axi_bid, m_axi_rid, m_axi_rlast, addr[1:0], m_axi_bresp, m_axi_rresp};
`endif

    assign rdata         = r_rdata;
    assign ready         = r_ready;

    assign m_axi_awid    = 1'b0;
    assign m_axi_awaddr  = r_addr;
    assign m_axi_awlen   = 8'd0;
    assign m_axi_awsize  = 3'd2;
    assign m_axi_awburst = 2'b01;
    assign m_axi_awlock  = 1'b0;
    assign m_axi_awcache = 4'b0011;
    assign m_axi_awprot  = 3'b010;
    assign m_axi_awqos   = 4'd0;
    assign m_axi_wdata   = r_wdata;
    assign m_axi_wstrb   = r_wstrb;
    assign m_axi_wlast   = 1'b1;

    assign m_axi_arid    = 1'b0;
    assign m_axi_araddr  = r_addr;
    assign m_axi_arlen   = 8'd0;
    assign m_axi_arsize  = 3'd2;
    assign m_axi_arburst = 2'b01;
    assign m_axi_arlock  = 1'b0;
    assign m_axi_arcache = 4'b0011;
    assign m_axi_arprot  = 3'b010;
    assign m_axi_arqos   = 4'd0;

endmodule

// File: tb/tb_iob_axi_master.sv
`timescale 1ns/1ps
module tb_iob_axi_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid;
    logic [31:0] addr, wdata, rdata;
    logic [3:0]  wstrb;
    logic        ready;
    logic        m_axi_awid, m_axi_awlock, m_axi_awvalid, m_axi_awready;
    logic [31:0] m_axi_awaddr;
    logic [7:0]  m_axi_awlen;
    logic [2:0]  m_axi_awsize, m_axi_awprot;
    logic [1:0]  m_axi_awburst;
    logic [3:0]  m_axi_awcache, m_axi_awqos;
    logic [31:0] m_axi_wdata;
    logic [3:0]  m_axi_wstrb;
    logic        m_axi_wlast, m_axi_wvalid, m_axi_wready;
    logic        m_axi_bid, m_axi_bvalid, m_axi_bready;
    logic [1:0]  m_axi_bresp;
    logic        m_axi_arid, m_axi_arlock, m_axi_arvalid, m_axi_arready;
    logic [31:0] m_axi_araddr;
    logic [7:0]  m_axi_arlen;
    logic [2:0]  m_axi_arsize, m_axi_arprot;
    logic [1:0]  m_axi_arburst;
    logic [3:0]  m_axi_arcache, m_axi_arqos;
    logic        m_axi_rid, m_axi_rlast, m_axi_rvalid, m_axi_rready;
    logic [31:0] m_axi_rdata;
    logic [1:0]  m_axi_rresp;
`ifdef IOB_AXI_MASTER_ERR_EN
    logic        err;
`endif

    iob_axi_master #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst), .valid(valid), .addr(addr), .wdata(wdata), .wstrb(wstrb),
        .rdata(rdata), .ready(ready),
        .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
        .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst), .m_axi_awlock(m_axi_awlock),
        .m_axi_awcache(m_axi_awcache), .m_axi_awprot(m_axi_awprot), .m_axi_awqos(m_axi_awqos),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
        .m_axi_bready(m_axi_bready),
        .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
        .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock),
        .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot), .m_axi_arqos(m_axi_arqos),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
`ifdef IOB_AXI_MASTER_ERR_EN
        , .err(err)
`endif
    );

    initial forever #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Slave knobs and observation state
    bit          zero_wait  = 1'b1;
    int          w_after_aw = -1;
    bit          hold_b     = 1'b0;
    int          force_resp = -1;
    int          cyc_g      = 0;
    int          n_ready    = 0;
    int          n_ar_total = 0;
    int          aw_cyc, w_cyc;
    bit          aw_first;
    logic [1:0]  last_resp;
    logic [31:0] mon_aw[$], mon_ar[$], mon_wd[$];
    logic [3:0]  mon_ws[$];
    logic [31:0] smem[int];
    logic [31:0] ref_mem[int];

    // Slave-internal state
    bit          aw_pend, w_pend, b_pend, r_pend, aw_seen;
    int          b_cd, r_cd, w_gate;
    logic [31:0] aw_pa, w_pd, r_pa;
    logic [3:0]  w_ps;
    logic        p_awv, p_wv, p_bready, p_arv, p_rready;
    logic [31:0] p_awaddr, p_wdata, p_araddr;
    logic [3:0]  p_wstrb;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    function automatic logic [1:0] pick_resp();
        if (force_resp >= 0) return force_resp[1:0];
        if (zero_wait) return 2'b00;
        return ($urandom_range(0, 3) == 0) ? 2'b10 : 2'b00;
    endfunction

    task automatic s_init();
        m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_arready = 1'b0;
        m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00; m_axi_bid = 1'b0;
        m_axi_rvalid = 1'b0; m_axi_rresp = 2'b00; m_axi_rid = 1'b0;
        m_axi_rlast = 1'b1; m_axi_rdata = '0;
        aw_pend = 0; w_pend = 0; b_pend = 0; r_pend = 0; aw_seen = 0; w_gate = 0;
        p_awv = 0; p_wv = 0; p_bready = 0; p_arv = 0; p_rready = 0;
        p_awaddr = '0; p_wdata = '0; p_araddr = '0; p_wstrb = '0;
    endtask

    // AXI slave: acts #1 after each edge on handshakes completed at that edge
    initial begin
        s_init();
        forever begin
            @(posedge clk); #1;
            cyc_g++;
            if (ready === 1'b1) n_ready++;
            if (rst === 1'b1) begin
                s_init();
                continue;
            end
            if (p_awv && m_axi_awready) begin
                mon_aw.push_back(p_awaddr); aw_cyc = cyc_g;
                aw_pend = 1; aw_pa = p_awaddr; aw_seen = 1; w_gate = w_after_aw;
            end
            if (p_wv && m_axi_wready) begin
                mon_wd.push_back(p_wdata); mon_ws.push_back(p_wstrb); w_cyc = cyc_g;
                w_pend = 1; w_pd = p_wdata; w_ps = p_wstrb; aw_seen = 0;
            end
            if (p_bready && m_axi_bvalid) m_axi_bvalid = 1'b0;
            if (p_arv && m_axi_arready) begin
                mon_ar.push_back(p_araddr); n_ar_total++;
                r_pend = 1; r_pa = p_araddr; r_cd = zero_wait ? 0 : $urandom_range(0, 3);
            end
            if (p_rready && m_axi_rvalid) m_axi_rvalid = 1'b0;
            if (aw_pend && w_pend) begin
                smem[int'(aw_pa[31:2])] = merge(smem.exists(int'(aw_pa[31:2])) ?
                                                smem[int'(aw_pa[31:2])] : 32'h0, w_pd, w_ps);
                aw_pend = 0; w_pend = 0; b_pend = 1;
                b_cd = zero_wait ? 0 : $urandom_range(0, 3);
            end
            if (b_pend && !hold_b) begin
                if (b_cd == 0) begin
                    m_axi_bvalid = 1'b1; m_axi_bresp = pick_resp(); last_resp = m_axi_bresp;
                    b_pend = 0;
                end else b_cd--;
            end
            if (r_pend) begin
                if (r_cd == 0) begin
                    m_axi_rvalid = 1'b1; m_axi_rresp = pick_resp(); last_resp = m_axi_rresp;
                    m_axi_rdata = smem.exists(int'(r_pa[31:2])) ? smem[int'(r_pa[31:2])] : 32'h0;
                    r_pend = 0;
                end else r_cd--;
            end
            m_axi_awready = zero_wait ? 1'b1 : 1'($urandom_range(0, 1));
            m_axi_arready = zero_wait ? 1'b1 : 1'($urandom_range(0, 1));
            if (w_after_aw >= 0) begin
                if (w_gate > 0) w_gate--;
                m_axi_wready = aw_seen && (w_gate == 0);
            end else begin
                m_axi_wready = zero_wait ? 1'b1 : 1'($urandom_range(0, 1));
            end
            if (!m_axi_awvalid && m_axi_wvalid) aw_first = 1'b1;
            p_awv = m_axi_awvalid; p_wv = m_axi_wvalid; p_bready = m_axi_bready;
            p_arv = m_axi_arvalid; p_rready = m_axi_rready;
            p_awaddr = m_axi_awaddr; p_wdata = m_axi_wdata; p_wstrb = m_axi_wstrb;
            p_araddr = m_axi_araddr;
        end
    end

    logic [31:0] last_rd = 32'h0;

    task automatic mon_clear();
        mon_aw.delete(); mon_wd.delete(); mon_ws.delete(); mon_ar.delete();
    endtask

    task automatic idle(input int n);
        valid = 1'b0;
        repeat (n) begin @(posedge clk); #2; end
    endtask

    // One native request. Returns #2 into the ready cycle. b2b: presented
    // during the previous ready cycle, so acceptance is one edge later.
    task automatic do_req(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input bit b2b);
        int lat;
        bit done;
        bit lat_chk;
        logic [31:0] exp_rd;
        lat_chk = zero_wait && (w_after_aw < 0);
        exp_rd = ref_mem.exists(int'(a[31:2])) ? ref_mem[int'(a[31:2])] : 32'h0;
        if (s != 4'h0) ref_mem[int'(a[31:2])] = merge(exp_rd, d, s);
        valid = 1'b1; addr = a; wdata = d; wstrb = s;
        done = 0; lat = 0;
        for (int c = 1; c <= 100 && !done; c++) begin
            @(posedge clk); #2;
            if (c == 1) chk("ready_low_first", ready, 1'b0);
            if (c == (b2b ? 2 : 1)) begin
                addr = $urandom; wdata = $urandom; wstrb = 4'($urandom);
            end
            if (ready === 1'b1) begin done = 1; lat = c; end
        end
        if (!done) begin
            chk("ready_seen", ready, 1'b1);
        end else begin
            if (lat_chk) chk("latency", lat, b2b ? 4 : 3);
            if (s != 4'h0) begin
                chk("aw_count", mon_aw.size(), 1);
                chk("w_count", mon_wd.size(), 1);
                chk("ar_count_wr", mon_ar.size(), 0);
                if (mon_aw.size() > 0) chk("awaddr", mon_aw[0], {a[31:2], 2'b00});
                if (mon_wd.size() > 0) begin
                    chk("wdata", mon_wd[0], d);
                    chk("wstrb", mon_ws[0], s);
                end
                chk("rdata_hold", rdata, last_rd);
            end else begin
                chk("ar_count", mon_ar.size(), 1);
                chk("aw_count_rd", mon_aw.size(), 0);
                if (mon_ar.size() > 0) chk("araddr", mon_ar[0], {a[31:2], 2'b00});
                chk("rdata", rdata, exp_rd);
                last_rd = exp_rd;
            end
`ifdef IOB_AXI_MASTER_ERR_EN
            chk("err", err, last_resp != 2'b00);
`endif
        end
        mon_clear();
    endtask

    task automatic reset_test();
        int rd0;
        bit got;
        hold_b = 1'b1;
        rd0 = n_ready;
        valid = 1'b1; addr = 32'h2000; wdata = 32'hCAFEF00D; wstrb = 4'hF;
        got = 0;
        for (int c = 0; c < 50 && !got; c++) begin
            @(posedge clk); #2;
            if (m_axi_bready === 1'b1) got = 1;
        end
        chk("reach_wr_resp", m_axi_bready, 1'b1);
        valid = 1'b0; rst = 1'b1;
        @(posedge clk); #2;
        chk("rst_mid_valids", {m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready}, 5'b0);
        chk("rst_mid_ready", ready, 1'b0);
        chk("rst_mid_rdata", rdata, 32'h0);
        last_rd = 32'h0;
        rst = 1'b0; hold_b = 1'b0;
        idle(5);
        chk("rst_no_ready", n_ready - rd0, 0);
        mon_clear();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ar0, rd0, gap;
        logic [31:0] a;
        logic [3:0]  s;
        rst = 1'b1; valid = 1'b0; addr = '0; wdata = '0; wstrb = '0;
        repeat (3) begin @(posedge clk); #2; end
        chk("rst_ready", ready, 1'b0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_valids", {m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready}, 5'b0);
        chk("aw_attr", {m_axi_awid, m_axi_awlen, m_axi_awsize, m_axi_awburst, m_axi_awlock,
                        m_axi_awcache, m_axi_awprot, m_axi_awqos},
                       {1'b0, 8'd0, 3'd2, 2'b01, 1'b0, 4'b0011, 3'b010, 4'd0});
        chk("ar_attr", {m_axi_arid, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arlock,
                        m_axi_arcache, m_axi_arprot, m_axi_arqos},
                       {1'b0, 8'd0, 3'd2, 2'b01, 1'b0, 4'b0011, 3'b010, 4'd0});
        chk("wlast", m_axi_wlast, 1'b1);
        rst = 1'b0;
        idle(1);

        // zero-wait write, then read back
        do_req(32'h100, 32'hDEADBEEF, 4'hF, 1'b0);
        chk("aw_w_same_cycle", w_cyc - aw_cyc, 0);
        idle(1);
        do_req(32'h100, 32'h0, 4'h0, 1'b0);
        idle(3);
        chk("rdata_stable", rdata, 32'hDEADBEEF);

        // skewed AW/W handshakes
        w_after_aw = 4; aw_first = 1'b0;
        do_req(32'h203, 32'h11223344, 4'h3, 1'b0);
        chk("aw_drops_first", aw_first, 1'b1);
        chk("w_skew", w_cyc - aw_cyc, 4);
        w_after_aw = -1;
        idle(1);

        // back-to-back reads with valid held high
        ar0 = n_ar_total; rd0 = n_ready;
        do_req(32'h0, 32'h0, 4'h0, 1'b0);
        do_req(32'h4, 32'h0, 4'h0, 1'b1);
        do_req(32'h8, 32'h0, 4'h0, 1'b1);
        idle(3);
        chk("b2b_ar", n_ar_total - ar0, 3);
        chk("b2b_ready", n_ready - rd0, 3);

        // reset while waiting for the write response
        reset_test();
        do_req(32'h100, 32'h0, 4'h0, 1'b0);
        chk("post_rst_read", rdata, 32'hDEADBEEF);

        // randomized traffic against the reference memory
        for (int i = 0; i < 150; i++) begin
            zero_wait = ($urandom_range(0, 3) == 0);
            a = {26'd0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
            s = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            gap = $urandom_range(0, 2);
            if (gap > 0) idle(gap);
            do_req(a, $urandom, s, gap == 0);
        end
        idle(2);
        zero_wait = 1'b1;

`ifdef IOB_AXI_MASTER_ERR_EN
        force_resp = 2;
        do_req(32'h100, 32'h0, 4'h0, 1'b0);
        chk("err_set", err, 1'b1);
        force_resp = 0;
        do_req(32'h100, 32'h0, 4'h0, 1'b1);
        chk("err_clear", err, 1'b0);
        force_resp = -1;
        idle(2);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/iob_axi_master.md
IOB_AXI_MASTER -- requirements
Module: iob_axi_master

Interface
REQ-001 Parameter ADDR_W, default 32: native and AXI address width.
REQ-002 Parameter DATA_W, default 32: data width; only 32 is supported.
REQ-003 clk  input  1  system clock; all logic on the rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 valid  input  1  native request; held high by the requester until ready.
REQ-006 addr  input  ADDR_W  native byte address.
REQ-007 wdata  input  DATA_W  native write data.
REQ-008 wstrb  input  DATA_W/8  byte enables; zero means read, nonzero means write.
REQ-009 rdata  output  DATA_W  read data, registered.
REQ-010 ready  output  1  one-cycle completion pulse.
REQ-011 AXI4 master ports m_axi_aw*, w*, b*, ar*, r*, with standard directions and widths: ID 1 bit, len 8, size 3, burst 2, lock 1, cache 4, prot 3, qos 4, resp 2.

Function
REQ-012 The FSM SHALL have states IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR and RD_DATA.
REQ-013 In IDLE with valid=1, the block SHALL register addr, wdata and wstrb.
  - Nonzero wstrb: go to WR_ADDR_DATA.
  - Zero wstrb: go to RD_ADDR.
REQ-014 AXI address outputs SHALL be the registered address with bits [1:0] forced to 0.
REQ-015 Constant AXI attributes SHALL be:
  - id 0, len 0, size 3'd2, burst 2'b01
  - lock 0, cache 4'b0011, prot 3'b010, qos 0
  - wlast 1
REQ-016 On entry to WR_ADDR_DATA, awvalid and wvalid SHALL both assert.
  - Each deasserts on the cycle after its own ready handshake.
  - Either order is allowed, including the same cycle.
REQ-017 When both the AW and W handshakes are done, the block SHALL move to WR_RESP with bready=1.
REQ-018 On bvalid&bready, the block SHALL pulse ready for one cycle and return to IDLE.
REQ-019 In RD_ADDR, arvalid SHALL be 1; on arready the block SHALL move to RD_DATA with rready=1.
REQ-020 On rvalid&rready, the block SHALL:
  - capture rdata, held stable until the next read completes;
  - pulse ready for one cycle;
  - return to IDLE.
  - rlast is ignored.
REQ-021 Minimum latency from valid to ready SHALL be 3 cycles for a write and 3 for a read, with zero-wait-state slave ready signals.
REQ-022 The block SHALL accept a request that is still valid in the first IDLE cycle after a ready pulse; the request present in the ready cycle itself SHALL NOT be re-sampled.
REQ-023 Changes to addr, wdata or wstrb after acceptance SHALL NOT affect the ongoing transaction.
REQ-024 The block SHALL have at most one outstanding AXI transaction; no request is accepted outside IDLE.

Reset
REQ-025 rst=1 SHALL force, at the next edge:
  - state IDLE;
  - all AXI valid and ready outputs 0;
  - ready 0, rdata 0.
REQ-026 Reset asserted mid-transaction SHALL abandon it without completion; the AXI slave is reset concurrently by the system.

Configuration
REQ-027 Macro IOB_AXI_MASTER_ERR_EN defined: the block SHALL add output err (1 bit, reset 0).
  - err is valid only while ready=1.
  - err = 1 when the captured bresp or rresp is nonzero.
REQ-028 Macro IOB_AXI_MASTER_ERR_EN undefined: the err port SHALL be absent and bresp/rresp SHALL be ignored.

Verification
REQ-029 Write, zero-wait slave: addr=0x100, wdata=0xDEADBEEF, wstrb=0xF.
  - AW and W accepted on the same cycle with awaddr=0x100.
  - ready pulses once at cycle 3.
REQ-030 Write with skewed handshakes: addr=0x203 (awaddr=0x200), wstrb=0x3; wready delayed 4 cycles after awready.
  - awvalid drops first.
  - Exactly one W beat with wstrb=0x3 follows, then ready after bvalid.
REQ-031 Read from addr=0x100 after REQ-029: arvalid with araddr=0x100 → rdata=0xDEADBEEF when ready pulses; rdata stays stable afterwards.
REQ-032 Back-to-back: valid held high across 3 reads (0x0, 0x4, 0x8) → exactly 3 ar handshakes and 3 ready pulses, no duplicates.
REQ-033 Reset in WR_RESP: bvalid withheld, rst=1 for 1 cycle → all valids 0, ready never pulses; the next read completes normally.
REQ-034 With IOB_AXI_MASTER_ERR_EN defined: slave returns rresp=2'b10 → err=1 with ready; the following OKAY read → err=0.
